counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
Sequencing controller for the 8-bit up/down counter. Accepts "move to target" commands over a valid/ready handshake and drives the counter's enable (E) and mode (M) inputs until the counter output equals the target. It observes the counter's Q and Cout outputs. It reports step count, wrap and abort status on a one-cycle done pulse. An optional prescaler sets the step rate.

Parameters:
STEP_DIV, 1, clock cycles per counter step (1..65535); prescaler width is 16 bits.

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous reset, active-low
cmd_valid  input  1  command request
cmd_ready  output  1  high when a command can be accepted (state IDLE)
cmd_target  input  8  target counter value
cmd_mode  input  2  00 shortest path, 01 up only, 10 down only, 11 treated as 00
abort  input  1  terminate the running command
cnt_Q  input  8  counter output Q
cnt_Cout  input  1  counter carry out
cnt_E  output  1  counter enable (combinational)
cnt_M  output  1  counter direction, 1=up (registered)
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at command completion
done_steps  output  8  steps taken by the last command
done_wrap  output  1  last command crossed FF<->00
done_abort  output  1  last command ended by abort

Behaviour:
- Reset values: state IDLE; cnt_M=1; done=0; done_steps=0; done_wrap=0; done_abort=0; prescaler=0; internal target=0.
- Handshake:
  - cmd_ready = (state==IDLE).
  - Accept when cmd_valid && cmd_ready.
  - Latch cmd_target and the resolved direction at acceptance.
  - Clear the step counter, wrap flag and prescaler.
- Direction resolution at accept, using cnt_Q that cycle:
  - up_d = (tgt - cnt_Q) mod 256; dn_d = (cnt_Q - tgt) mod 256.
  - Mode 00/11: up if up_d <= dn_d (the tie at 128 goes up).
  - Mode 01: up. Mode 10: down.
- Accept with tgt == cnt_Q: go directly to DONE with steps=0 and wrap=0.
- States and transitions:
  - IDLE -> RUN on accept (or -> DONE for zero distance).
  - RUN -> DONE when cnt_Q == tgt, or when abort=1.
  - DONE -> IDLE unconditionally after 1 cycle.
- Step tick:
  - In RUN, the prescaler counts 0..STEP_DIV-1 and wraps.
  - tick = (prescaler == STEP_DIV-1). With STEP_DIV=1, tick=1 every RUN cycle.
  - The first step occurs in the STEP_DIV-th RUN cycle.
- cnt_E = (state==RUN) && tick && (cnt_Q != tgt) && !abort.
  - The counter updates Q on the next edge.
  - The controller sees cnt_Q == tgt the following cycle and never overshoots.
- cnt_M holds the resolved direction from accept to the next accept.
- Each cycle with cnt_E=1:
  - Increment the step counter (8-bit, saturating at 255; unreachable in a normal run).
  - Set wrap if (up && cnt_Cout) or (!up && cnt_Q==8'h00).
- Entry to DONE:
  - done=1 for exactly one cycle (registered, asserted in the DONE cycle).
  - done_steps, done_wrap and done_abort are loaded and held until the next DONE.
  - done_abort=1 only for the abort exit.
- Abort:
  - Ignored in IDLE and DONE.
  - In RUN it suppresses cnt_E in the same cycle.
  - If abort is asserted in the same cycle cnt_Q reaches tgt, report a normal completion (done_abort=0).
- Timing: a command of N steps with STEP_DIV=D completes with done at cycle N*D+1 after the accept cycle (D=1: done at cycle N+1; N=0: done at cycle 1).
- cmd_valid during busy: no accept; the requester holds the command until ready.
- Reset mid-operation: immediate return to reset values; cnt_E goes low asynchronously because state becomes IDLE.
- The counter is assumed driven only by this block; no other agent changes Q while busy.

Test Plan:
1. Reset, counter Q=00, cmd target=05 mode 00, STEP_DIV=1 -> cnt_M=1, cnt_E high 5 consecutive cycles, Q=05, done pulse with steps=5, wrap=0, abort=0.
2. Q=03, target=FD mode 00 -> down chosen (dn_d=6 < up_d=250), steps=6, wrap=1 (passes 00->FF), final Q=FD.
3. Q=FE, target=02 mode 01 -> up, cnt_Cout seen at Q=FF, steps=4, wrap=1; then target=02 again -> zero-step done one cycle after accept, steps=0.
4. STEP_DIV=4, Q=10, target=13 mode 00 -> cnt_E high only in every 4th RUN cycle, done at cycle 13 after accept, steps=3.
5. Q=00, target=80 mode 00 -> tie resolves up; abort asserted after 10 steps -> cnt_E drops the same cycle, Q=0A, done with steps=10, abort=1.
6. Assert cmd_valid while busy -> cmd_ready=0, no accept until after the done cycle. Assert Reset low mid-RUN -> cnt_E=0, busy=0, done outputs cleared immediately.

Source files
------------

// File: rtl/counter_seq_ctrl_if.sv
// Command/status bundle between a requester and the counter sequencing controller.
// The requester drives the command side; the controller drives ready, busy and the done report.
interface counter_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_target;
  logic [1:0] cmd_mode;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] done_steps;
  logic       done_wrap;
  logic       done_abort;

  modport master (
    output cmd_valid, cmd_target, cmd_mode, abort,
    input  cmd_ready, busy, done, done_steps, done_wrap, done_abort
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_mode, abort,
    output cmd_ready, busy, done, done_steps, done_wrap, done_abort
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Drives an 8-bit up/down counter from its current value to a commanded target,
// one step per prescaler tick, and reports steps/wrap/abort with a done pulse.
//
// state | meaning
// IDLE  | ready for a command
// RUN   | stepping the counter toward the latched target
// DONE  | one-cycle completion report, then back to IDLE
module counter_seq_ctrl #(
  parameter int STEP_DIV = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  counter_seq_ctrl_if.slave  bus,
  input  logic [7:0]         cnt_Q,
  input  logic               cnt_Cout,
  output logic               cnt_E,
  output logic               cnt_M
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] DIV_LAST = 16'(STEP_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  tgt_q, tgt_d;
  logic        up_q, up_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  steps_q, steps_d;
  logic        wrap_q, wrap_d;
  logic        done_q, done_d;
  logic [7:0]  done_steps_q, done_steps_d;
  logic        done_wrap_q, done_wrap_d;
  logic        done_abort_q, done_abort_d;

  logic [7:0]  up_dist, dn_dist, q_step, steps_inc;
  logic        dir_up, tick, wrap_hit;

  always_comb begin
    up_dist   = bus.cmd_target - cnt_Q;
    dn_dist   = cnt_Q - bus.cmd_target;
    case (bus.cmd_mode)
      2'b01:   dir_up = 1'b1;
      2'b10:   dir_up = 1'b0;
      default: dir_up = (up_dist <= dn_dist);
    endcase
    tick      = (presc_q == DIV_LAST);
    cnt_E     = (state_q == RUN) && tick && (cnt_Q != tgt_q) && !bus.abort;
    q_step    = up_q ? cnt_Q + 8'd1 : cnt_Q - 8'd1;
    steps_inc = (steps_q == 8'hFF) ? steps_q : steps_q + 8'd1;
    wrap_hit  = (up_q && cnt_Cout) || (!up_q && (cnt_Q == 8'h00));

    state_d      = state_q;
    tgt_d        = tgt_q;
    up_d         = up_q;
    presc_d      = presc_q;
    steps_d      = steps_q;
    wrap_d       = wrap_q;
    done_d       = 1'b0;
    done_steps_d = done_steps_q;
    done_wrap_d  = done_wrap_q;
    done_abort_d = done_abort_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          tgt_d   = bus.cmd_target;
          up_d    = dir_up;
          presc_d = '0;
          steps_d = '0;
          wrap_d  = 1'b0;
          if (bus.cmd_target == cnt_Q) begin
            state_d      = DONE;
            done_d       = 1'b1;
            done_steps_d = '0;
            done_wrap_d  = 1'b0;
            done_abort_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        presc_d = tick ? '0 : presc_q + 16'd1;
        if (cnt_E) begin
          steps_d = steps_inc;
          wrap_d  = wrap_q | wrap_hit;
        end
        // Leave on the step that lands on the target so done follows it by one cycle.
        if ((cnt_Q == tgt_q) || (cnt_E && (q_step == tgt_q))) begin
          state_d      = DONE;
          done_d       = 1'b1;
          done_steps_d = steps_d;
          done_wrap_d  = wrap_d;
          done_abort_d = 1'b0;
        end else if (bus.abort) begin
          state_d      = DONE;
          done_d       = 1'b1;
          done_steps_d = steps_q;
          done_wrap_d  = wrap_q;
          done_abort_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      tgt_q        <= '0;
      up_q         <= 1'b1;
      presc_q      <= '0;
      steps_q      <= '0;
      wrap_q       <= 1'b0;
      done_q       <= 1'b0;
      done_steps_q <= '0;
      done_wrap_q  <= 1'b0;
      done_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      up_q         <= up_d;
      presc_q      <= presc_d;
      steps_q      <= steps_d;
      wrap_q       <= wrap_d;
      done_q       <= done_d;
      done_steps_q <= done_steps_d;
      done_wrap_q  <= done_wrap_d;
      done_abort_q <= done_abort_d;
    end
  end

  assign cnt_M          = up_q;
  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.done_steps = done_steps_q;
  assign bus.done_wrap  = done_wrap_q;
  assign bus.done_abort = done_abort_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: two instances (step divider 1 and 4), each driving a modelled
// up/down counter, checked every cycle against a distance-based model plus literal expectations.
module tb_counter_seq_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  logic [1:0] b_valid = '0, b_abort = '0, b_ld = '0;
  logic [7:0] b_target [2];
  logic [1:0] b_mode   [2];
  logic [7:0] b_ldval  [2];

  wire [1:0]  o_ready, o_busy, o_done, o_wrap, o_abort, o_E, o_M;
  wire [15:0] o_steps, o_q;

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D = (g == 1) ? 4 : 1;
    counter_seq_ctrl_if ifc ();
    logic [7:0] q;
    logic       cout, e, m;

    assign ifc.cmd_valid  = b_valid[g];
    assign ifc.cmd_target = b_target[g];
    assign ifc.cmd_mode   = b_mode[g];
    assign ifc.abort      = b_abort[g];

    // The counter being sequenced: loadable 8-bit up/down counter, carry out at FF counting up.
    always @(posedge Clk) begin
      if (b_ld[g]) q <= b_ldval[g];
      else if (e)  q <= m ? q + 8'd1 : q - 8'd1;
    end
    assign cout = m && (q == 8'hFF);

    counter_seq_ctrl #(.STEP_DIV(D)) u_dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .bus      (ifc.slave),
      .cnt_Q    (q),
      .cnt_Cout (cout),
      .cnt_E    (e),
      .cnt_M    (m)
    );

    assign o_ready[g]       = ifc.cmd_ready;
    assign o_busy[g]        = ifc.busy;
    assign o_done[g]        = ifc.done;
    assign o_wrap[g]        = ifc.done_wrap;
    assign o_abort[g]       = ifc.done_abort;
    assign o_steps[g*8 +: 8] = ifc.done_steps;
    assign o_E[g]           = e;
    assign o_M[g]           = m;
    assign o_q[g*8 +: 8]    = q;
  end

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", name, g, act, exp, $time);
    end
  endtask

  function automatic logic wrap_of(input logic [7:0] start, input int n, input logic up);
    return up ? (int'(start) + n > 255) : (n > int'(start));
  endfunction

  // Model: distance picks direction and step count; steps land on every D-th cycle after accept.
  int         m_phase [2] = '{0, 0};
  int         m_k [2], m_end [2], m_steps [2];
  logic       m_dir [2] = '{1'b1, 1'b1};
  logic       m_ab [2];
  logic [7:0] m_start [2];
  logic [7:0] m_ls [2] = '{8'h00, 8'h00};
  logic       m_lw [2] = '{1'b0, 1'b0};
  logic       m_la [2] = '{1'b0, 1'b0};

  always @(negedge Clk) begin
    for (int g = 0; g < 2; g++) begin
      int d, upd, dnd;
      logic ee, ed;
      logic [7:0] qv, fin;
      d  = (g == 1) ? 4 : 1;
      qv = o_q[g*8 +: 8];
      if (!Reset) begin
        m_phase[g] = 0;
        m_dir[g]   = 1'b1;
        m_ls[g]    = 8'h00;
        m_lw[g]    = 1'b0;
        m_la[g]    = 1'b0;
      end else begin
        ee = 1'b0;
        ed = 1'b0;
        if (m_phase[g] == 1) begin
          m_k[g]++;
          if (m_k[g] == m_end[g]) begin
            ed      = 1'b1;
            m_ls[g] = 8'(m_steps[g]);
            m_lw[g] = wrap_of(m_start[g], m_steps[g], m_dir[g]);
            m_la[g] = m_ab[g];
          end else if (b_abort[g]) begin
            m_end[g] = m_k[g] + 1;
            m_ab[g]  = 1'b1;
          end else if (m_k[g] % d == 0) begin
            ee = 1'b1;
            m_steps[g]++;
          end
        end
        check("cnt_E", g, o_E[g], ee);
        check("done", g, o_done[g], ed);
        check("busy", g, o_busy[g], m_phase[g] != 0);
        check("cmd_ready", g, o_ready[g], m_phase[g] == 0);
        check("cnt_M", g, o_M[g], m_dir[g]);
        check("done_steps", g, o_steps[g*8 +: 8], m_ls[g]);
        check("done_wrap", g, o_wrap[g], m_lw[g]);
        check("done_abort", g, o_abort[g], m_la[g]);
        if (ed) begin
          fin = m_dir[g] ? m_start[g] + 8'(m_steps[g]) : m_start[g] - 8'(m_steps[g]);
          check("final_q", g, qv, fin);
          m_phase[g] = 0;
        end else if (m_phase[g] == 0 && b_valid[g]) begin
          upd = int'(8'(b_target[g] - qv));
          dnd = int'(8'(qv - b_target[g]));
          case (b_mode[g])
            2'b01:   m_dir[g] = 1'b1;
            2'b10:   m_dir[g] = 1'b0;
            default: m_dir[g] = (upd <= dnd);
          endcase
          m_start[g] = qv;
          m_steps[g] = 0;
          m_ab[g]    = 1'b0;
          m_k[g]     = 0;
          m_end[g]   = (m_dir[g] ? upd : dnd) * d + 1;
          m_phase[g] = 1;
        end
      end
    end
  end

  task automatic load(input int g, input logic [7:0] v);
    @(posedge Clk); #1;
    b_ld[g] = 1'b1;
    b_ldval[g] = v;
    @(posedge Clk); #1;
    b_ld[g] = 1'b0;
  endtask

  // Issues one command; returns the cycle (1 = first after accept) in which done is seen, -1 if never.
  task automatic run_cmd(input int g, input logic [7:0] tgt, input logic [1:0] mode,
                         input int abort_after, output int done_k);
    int k, ec, waitc;
    done_k = -1;
    @(posedge Clk); #1;
    b_valid[g]  = 1'b1;
    b_target[g] = tgt;
    b_mode[g]   = mode;
    waitc = 0;
    forever begin
      @(negedge Clk);
      if (o_ready[g] || waitc > 200) break;
      waitc++;
    end
    check("accept_seen", g, o_ready[g], 1'b1);
    @(posedge Clk); #1;
    b_valid[g] = 1'b0;
    k  = 1;
    ec = 0;
    while (k < 2000) begin
      if (abort_after >= 0 && ec == abort_after) b_abort[g] = 1'b1;
      @(negedge Clk);
      if (o_E[g]) ec++;
      if (o_done[g]) begin
        done_k = k;
        break;
      end
      @(posedge Clk); #1;
      k++;
    end
    b_abort[g] = 1'b0;
    check("done_seen", g, done_k >= 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int dk, k;
    for (int i = 0; i < 2; i++) begin
      b_target[i] = '0;
      b_mode[i]   = '0;
      b_ldval[i]  = '0;
    end
    repeat (3) @(negedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    check("rst_M", 0, o_M[0], 1'b1);
    check("rst_ready", 0, o_ready[0], 1'b1);
    check("rst_steps", 1, o_steps[15:8], 8'h00);

    // 1: 00 -> 05 shortest path, up
    load(0, 8'h00);
    run_cmd(0, 8'h05, 2'b00, -1, dk);
    check("t1_done_cycle", 0, dk, 6);
    check("t1_steps", 0, o_steps[7:0], 8'd5);
    check("t1_wrap", 0, o_wrap[0], 1'b0);
    check("t1_q", 0, o_q[7:0], 8'h05);
    check("t1_M", 0, o_M[0], 1'b1);

    // 2: 03 -> FD shortest path goes down through 00
    load(0, 8'h03);
    run_cmd(0, 8'hFD, 2'b00, -1, dk);
    check("t2_done_cycle", 0, dk, 7);
    check("t2_steps", 0, o_steps[7:0], 8'd6);
    check("t2_wrap", 0, o_wrap[0], 1'b1);
    check("t2_M", 0, o_M[0], 1'b0);
    check("t2_q", 0, o_q[7:0], 8'hFD);

    // 3: FE -> 02 up only, then same target again (zero distance)
    load(0, 8'hFE);
    run_cmd(0, 8'h02, 2'b01, -1, dk);
    check("t3_done_cycle", 0, dk, 5);
    check("t3_steps", 0, o_steps[7:0], 8'd4);
    check("t3_wrap", 0, o_wrap[0], 1'b1);
    run_cmd(0, 8'h02, 2'b01, -1, dk);
    check("t3z_done_cycle", 0, dk, 1);
    check("t3z_steps", 0, o_steps[7:0], 8'd0);
    check("t3z_wrap", 0, o_wrap[0], 1'b0);

    // 5: 00 -> 80 tie goes up, aborted after 10 steps
    load(0, 8'h00);
    run_cmd(0, 8'h80, 2'b00, 10, dk);
    check("t5_done_cycle", 0, dk, 12);
    check("t5_steps", 0, o_steps[7:0], 8'd10);
    check("t5_abort", 0, o_abort[0], 1'b1);
    check("t5_q", 0, o_q[7:0], 8'h0A);
    check("t5_M", 0, o_M[0], 1'b1);

    // mode 11 behaves as shortest path: 0A -> 05 goes down
    run_cmd(0, 8'h05, 2'b11, -1, dk);
    check("m11_done_cycle", 0, dk, 6);
    check("m11_M", 0, o_M[0], 1'b0);
    check("m11_abort", 0, o_abort[0], 1'b0);

    // 4: divide-by-4 instance, 10 -> 13
    load(1, 8'h10);
    run_cmd(1, 8'h13, 2'b00, -1, dk);
    check("t4_done_cycle", 1, dk, 13);
    check("t4_steps", 1, o_steps[15:8], 8'd3);
    check("t4_q", 1, o_q[15:8], 8'h13);

    // 6: requester holds a second command while busy, then reset mid-run
    @(posedge Clk); #1;
    b_valid[0]  = 1'b1;
    b_target[0] = 8'h09;
    b_mode[0]   = 2'b00;
    @(negedge Clk);
    check("t6_ready_a", 0, o_ready[0], 1'b1);
    @(posedge Clk); #1;
    b_target[0] = 8'h02;
    b_mode[0]   = 2'b10;
    k = 1;
    forever begin
      @(negedge Clk);
      if (o_ready[0] || k > 50) break;
      k++;
    end
    check("t6_ready_cycle", 0, k, 6);
    check("t6_a_steps", 0, o_steps[7:0], 8'd4);
    @(posedge Clk); #1;
    b_valid[0] = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    check("t6_E_before_rst", 0, o_E[0], 1'b1);
    check("t6_M_before_rst", 0, o_M[0], 1'b0);
    Reset = 1'b0;
    #1;
    check("t6_rst_E", 0, o_E[0], 1'b0);
    check("t6_rst_busy", 0, o_busy[0], 1'b0);
    check("t6_rst_ready", 0, o_ready[0], 1'b1);
    check("t6_rst_M", 0, o_M[0], 1'b1);
    check("t6_rst_steps", 0, o_steps[7:0], 8'd0);
    check("t6_rst_done", 0, o_done[0], 1'b0);
    @(negedge Clk);
    #1 Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
